maxpool_stream: RTL and testbench
=================================

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 The block SHALL have parameter T, default 16, giving the signed sample width in bits.
REQ-002 The block SHALL have parameter POOL, default 2, giving the window size and stride; it SHALL be at least 2.
REQ-003 The block SHALL have parameter LEN, default 57, giving the samples per frame (one convolution output vector).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port x_data, input, T bits: signed input sample.
REQ-007 The block SHALL have port x_valid, input, 1 bit: x_data is valid.
REQ-008 The block SHALL have port x_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 The block SHALL have port y_data, output, T bits: signed pooled result.
REQ-010 The block SHALL have port y_valid, output, 1 bit: y_data is valid.
REQ-011 The block SHALL have port y_ready, input, 1 bit: the downstream consumer accepts y_data.

Function
REQ-012 An input transfer SHALL occur only when x_valid and x_ready are both high in the same cycle.
REQ-013 An output transfer SHALL occur only when y_valid and y_ready are both high in the same cycle.
REQ-014 x_ready SHALL equal (~y_valid | y_ready), combinationally.
REQ-015 The block SHALL group accepted samples, in order, into consecutive non-overlapping windows of POOL samples each.
REQ-016 The first sample of a window SHALL load the accumulator; each later sample SHALL replace it when the sample is greater under a signed comparison.
REQ-017 On acceptance of a window's last sample, the result SHALL load the output register and y_valid SHALL rise on the next cycle (latency 1).
REQ-018 y_data SHALL hold stable while y_valid is high and y_ready is low.
REQ-019 y_valid SHALL clear after an output transfer unless a new window completes in that same cycle; in that case it SHALL stay high with the new y_data.
REQ-020 The block SHALL count samples per frame; after LEN samples the window and frame counters SHALL return to 0.
REQ-021 The trailing (LEN mod POOL) samples of a frame SHALL be accepted and discarded, producing no output.
REQ-022 Each frame SHALL produce exactly floor(LEN/POOL) outputs, 28 at the defaults.
REQ-023 Idle cycles (x_valid low) mid-window SHALL leave the window state unchanged.

Reset
REQ-024 While reset is low, y_valid, the window counter, the frame counter and the accumulator SHALL be 0, asynchronously.
REQ-025 While reset is low, x_ready SHALL be 1, following REQ-014.
REQ-026 While reset is low, y_data SHALL be 0.
REQ-027 A reset asserted mid-window or mid-frame SHALL discard partial state; the first sample after release SHALL start a new frame.

Configuration
REQ-028 The macro MAXPOOL_AVG_EN SHALL select the pooling operation at compile time.
REQ-029 With MAXPOOL_AVG_EN defined, the block SHALL perform average pooling:
- sum the window in a T+$clog2(POOL)-bit signed accumulator;
- output the sum arithmetically right-shifted by log2(POOL), i.e. floor toward negative infinity;
- POOL SHALL be a power of two, checked by an elaboration-time assertion.
REQ-030 Without MAXPOOL_AVG_EN, the block SHALL perform max pooling per REQ-016.

Structure
REQ-031 Package maxpool_pkg SHALL hold the default T, POOL and LEN constants and typedef sample_t (logic signed [T-1:0]).
REQ-032 Sub-module maxpool_reduce SHALL contain the accumulator and window counter and flag window completion; maxpool_stream SHALL contain the frame counter, handshake and output register.

Verification
REQ-033 The bench SHALL apply a ramp x=0..56 with y_ready held high and check:
- 28 outputs 1,3,5,...,55;
- sample 56 dropped;
- each y_valid one cycle after its window completes.
REQ-034 The bench SHALL apply (-5,-3) and (-7,-9) and check outputs -3 then -7, confirming signed compare.
REQ-035 The bench SHALL hold y_ready low for 10 cycles with y_valid high and check:
- y_data stable;
- x_ready low;
- no sample lost or duplicated after release.
REQ-036 The bench SHALL stream with y_ready always high and x_valid always high and check:
- x_ready stays high throughout;
- an output every POOL cycles;
- back-to-back handshake per REQ-019 is exercised.
REQ-037 The bench SHALL assert reset low after 1 sample (value 100) of a window, release it, then send (2,3) and check:
- y_valid low during reset;
- next output is 3.
REQ-038 The bench SHALL, with MAXPOOL_AVG_EN defined, send (4,7) then (-3,-4) and check outputs 5 then -4.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared constants and sample type for the streaming max/average pooling block.
package maxpool_pkg;

    localparam int unsigned DEFAULT_T    = 16;
    localparam int unsigned DEFAULT_POOL = 2;
    localparam int unsigned DEFAULT_LEN  = 57;

    typedef logic signed [DEFAULT_T-1:0] sample_t;

    function automatic bit is_pow2(int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/maxpool_stream_if.sv
// Valid/ready sample stream in (x_*) and pooled result stream out (y_*).
interface maxpool_stream_if #(
    parameter int unsigned T = maxpool_pkg::DEFAULT_T
);
    logic signed [T-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
    logic signed [T-1:0] y_data;
    logic                y_valid;
    logic                y_ready;

    // Producer of samples and consumer of pooled results
    modport master (
        output x_data, x_valid, y_ready,
        input  x_ready, y_data, y_valid
    );

    // The pooling block itself
    modport slave (
        input  x_data, x_valid, y_ready,
        output x_ready, y_data, y_valid
    );
endinterface

// File: rtl/maxpool_reduce.sv
// Window accumulator and counter; flags the cycle a window's last sample arrives.
// MAXPOOL_AVG_EN selects average pooling instead of max pooling.
module maxpool_reduce
    import maxpool_pkg::*;
#(
    parameter int unsigned T    = DEFAULT_T,
    parameter int unsigned POOL = DEFAULT_POOL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [T-1:0] in_data,
    output logic                done_c,
    output logic signed [T-1:0] result_c
);

    localparam int unsigned CNT_W = $clog2(POOL);
`ifdef MAXPOOL_AVG_EN
    localparam int unsigned SHIFT = $clog2(POOL);
    localparam int unsigned ACC_W = T + SHIFT;
`else
    localparam int unsigned ACC_W = T;
`endif

    logic [CNT_W-1:0]        win_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic                    first;

    generate
        if (POOL < 2) begin : g_pool_too_small
            $error("maxpool_reduce: POOL must be at least 2");
        end
`ifdef MAXPOOL_AVG_EN
        if (!is_pow2(POOL)) begin : g_pool_not_pow2
            $error("maxpool_reduce: POOL must be a power of two for average pooling");
        end
`endif
    endgenerate

    // First sample of a window reloads; later samples fold in
    always_comb begin
        first  = (win_cnt == '0);
        done_c = in_valid && (win_cnt == CNT_W'(POOL - 1));
`ifdef MAXPOOL_AVG_EN
        acc_next = first ? ACC_W'(in_data) : (acc + ACC_W'(in_data));
        result_c = T'(acc_next >>> SHIFT);
`else
        acc_next = (first || (in_data > acc)) ? in_data : acc;
        result_c = acc_next;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt <= '0;
            acc     <= '0;
        end else if (in_valid) begin
            acc     <= acc_next;
            win_cnt <= done_c ? '0 : (win_cnt + CNT_W'(1));
        end
    end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming pooling over fixed-length frames: POOL-sample windows, trailing remainder dropped.
// Define MAXPOOL_AVG_EN for average pooling; default build is max pooling.
module maxpool_stream
    import maxpool_pkg::*;
#(
    parameter int unsigned T    = DEFAULT_T,
    parameter int unsigned POOL = DEFAULT_POOL,
    parameter int unsigned LEN  = DEFAULT_LEN
) (
    input  logic           clk,
    input  logic           reset,
    maxpool_stream_if.slave bus
);

    localparam int unsigned FRAME_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned KEEP    = (LEN / POOL) * POOL;

    logic [FRAME_W-1:0]  frame_cnt;
    logic                accept_c;
    logic                keep_c;
    logic                done_c;
    logic signed [T-1:0] result_c;
    logic signed [T-1:0] y_data_q;
    logic                y_valid_q;

    assign bus.x_ready = ~y_valid_q | bus.y_ready;
    assign bus.y_data  = y_data_q;
    assign bus.y_valid = y_valid_q;

    assign accept_c = bus.x_valid & bus.x_ready;
    // Samples past the last full window are accepted but never reach the reducer
    assign keep_c   = 32'(frame_cnt) < KEEP;

    maxpool_reduce #(
        .T    (T),
        .POOL (POOL)
    ) u_reduce (
        .clk      (clk),
        .reset    (reset),
        .in_valid (accept_c & keep_c),
        .in_data  (bus.x_data),
        .done_c   (done_c),
        .result_c (result_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (accept_c) begin
            frame_cnt <= (frame_cnt == FRAME_W'(LEN - 1)) ? '0 : (frame_cnt + FRAME_W'(1));
        end
    end

    // A completing window can only be accepted when the output slot is free or draining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else if (done_c) begin
            y_valid_q <= 1'b1;
            y_data_q  <= result_c;
        end else if (bus.y_ready) begin
            y_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream against a frame/window reference model.
module tb_maxpool_stream;
    import maxpool_pkg::*;

    localparam int unsigned T    = DEFAULT_T;
    localparam int unsigned POOL = DEFAULT_POOL;
    localparam int unsigned LEN  = DEFAULT_LEN;
    localparam int P_I    = POOL;
    localparam int LEN_I  = LEN;
    localparam int KEEP_I = (LEN_I / P_I) * P_I;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    maxpool_stream_if #(.T(T)) bus ();

    maxpool_stream #(.T(T), .POOL(POOL), .LEN(LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within frame, samples of the open window, pending results
    int exp_q[$];
    int win[$];
    int pos = 0;
    bit done_flag;

    task automatic model_reset();
        pos = 0;
        win.delete();
        exp_q.delete();
    endtask

    task automatic model_push(input int s);
        int r;
        int sum;
        done_flag = 1'b0;
        if (pos < KEEP_I) begin
            win.push_back(s);
            if (win.size() == P_I) begin
`ifdef MAXPOOL_AVG_EN
                sum = 0;
                foreach (win[i]) sum += win[i];
                r = sum / P_I;
                if (sum < 0 && (sum % P_I) != 0) r -= 1;
`else
                r = win[0];
                foreach (win[i]) if (win[i] > r) r = win[i];
`endif
                exp_q.push_back(r);
                win.delete();
                done_flag = 1'b1;
            end
        end
        pos = (pos + 1) % LEN_I;
    endtask

    task automatic pop_exp(output int e, output bit ok);
        ok = (exp_q.size() > 0);
        e  = 0;
        if (ok) e = exp_q.pop_front();
    endtask

    // One clock: drive inputs, observe at the falling edge, advance past the rising edge
    task automatic run_cycle(input logic vld, input sample_t d, input logic rdy,
                             output logic xr, output logic yv, output sample_t yd,
                             output bit dn);
        bus.x_valid = vld;
        bus.x_data  = d;
        bus.y_ready = rdy;
        @(negedge clk);
        xr = bus.x_ready;
        yv = bus.y_valid;
        yd = bus.y_data;
        dn = 1'b0;
        if (vld && xr) begin
            model_push(int'(d));
            dn = done_flag;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.x_valid = 1'b1;
        bus.x_data  = T'(55);
        bus.y_ready = 1'b0;
        #12;
        vectors++;
        if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid: got %b, required 0", bus.y_valid); end
        vectors++;
        if (bus.y_data !== '0) begin miscompares++; $display("FAIL reset_y_data: got %0d, required 0", bus.y_data); end
        vectors++;
        if (bus.x_ready !== 1'b1) begin miscompares++; $display("FAIL reset_x_ready: got %b, required 1", bus.x_ready); end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid_hold: got %b, required 0", bus.y_valid); end
        bus.x_valid = 1'b0;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_ramp();
        logic xr, yv, ev;
        sample_t yd;
        bit dn, ok;
        int k = 0;
        int e, want;
        for (int j = 0; j < 60; j++) begin
            run_cycle(logic'(j < 57), T'(j), 1'b1, xr, yv, yd, dn);
            ev = logic'((j % 2 == 0) && j >= 2 && j <= 56);
            vectors++;
            if (yv !== ev) begin miscompares++; $display("FAIL ramp_latency cycle %0d: got y_valid %b, required %b", j, yv, ev); end
            if (yv) begin
                pop_exp(e, ok);
`ifdef MAXPOOL_AVG_EN
                want = 2 * k;
`else
                want = 2 * k + 1;
`endif
                vectors++;
                if (int'(yd) !== want) begin miscompares++; $display("FAIL ramp_data #%0d: got %0d, required %0d", k, yd, want); end
                k++;
            end
        end
        vectors++;
        if (k !== 28) begin miscompares++; $display("FAIL ramp_count: got %0d, required 28", k); end
    endtask

    task automatic test_reset_mid();
        logic xr, yv;
        sample_t yd;
        bit dn, ok;
        int e, want;
        run_cycle(1'b1, T'(100), 1'b1, xr, yv, yd, dn);
        bus.x_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_y_valid: got %b, required 0", bus.y_valid); end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_y_valid_hold: got %b, required 0", bus.y_valid); end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        run_cycle(1'b1, T'(2), 1'b1, xr, yv, yd, dn);
        run_cycle(1'b1, T'(3), 1'b1, xr, yv, yd, dn);
        run_cycle(1'b0, T'(0), 1'b1, xr, yv, yd, dn);
`ifdef MAXPOOL_AVG_EN
        want = 2;
`else
        want = 3;
`endif
        pop_exp(e, ok);
        vectors++;
        if (yv !== 1'b1 || int'(yd) !== want) begin
            miscompares++; $display("FAIL midreset_first_out: got valid %b data %0d, required valid 1 data %0d", yv, yd, want);
        end
        run_cycle(1'b0, T'(0), 1'b1, xr, yv, yd, dn);
    endtask

    task automatic test_signed();
        int vals[6] = '{-5, -3, -7, -9, 0, 0};
        int want[2];
        logic xr, yv;
        sample_t yd;
        bit dn, ok;
        int e;
        int n = 0;
`ifdef MAXPOOL_AVG_EN
        want = '{-4, -8};
`else
        want = '{-3, -7};
`endif
        for (int i = 0; i < 6; i++) begin
            run_cycle(logic'(i < 4), T'(vals[i]), 1'b1, xr, yv, yd, dn);
            if (yv) begin
                pop_exp(e, ok);
                vectors++;
                if (n >= 2 || int'(yd) !== want[n % 2]) begin
                    miscompares++; $display("FAIL signed_out #%0d: got %0d, required %0d", n, yd, want[n % 2]);
                end
                n++;
            end
        end
        vectors++;
        if (n !== 2) begin miscompares++; $display("FAIL signed_count: got %0d, required 2", n); end
    endtask

    task automatic test_avg_pairs();
        int vals[6] = '{4, 7, -3, -4, 0, 0};
        int want[2];
        logic xr, yv;
        sample_t yd;
        bit dn, ok;
        int e;
        int n = 0;
`ifdef MAXPOOL_AVG_EN
        want = '{5, -4};
`else
        want = '{7, -3};
`endif
        for (int i = 0; i < 6; i++) begin
            run_cycle(logic'(i < 4), T'(vals[i]), 1'b1, xr, yv, yd, dn);
            if (yv) begin
                pop_exp(e, ok);
                vectors++;
                if (n >= 2 || int'(yd) !== want[n % 2]) begin
                    miscompares++; $display("FAIL pairs_out #%0d: got %0d, required %0d", n, yd, want[n % 2]);
                end
                n++;
            end
        end
        vectors++;
        if (n !== 2) begin miscompares++; $display("FAIL pairs_count: got %0d, required 2", n); end
    endtask

    task automatic test_backpressure();
        logic xr, yv;
        sample_t yd;
        bit dn, ok;
        int e, held;
        run_cycle(1'b1, T'($urandom), 1'b0, xr, yv, yd, dn);
        run_cycle(1'b1, T'($urandom), 1'b0, xr, yv, yd, dn);
        held = (exp_q.size() > 0) ? exp_q[0] : 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, T'($urandom), 1'b0, xr, yv, yd, dn);
            vectors++;
            if (yv !== 1'b1) begin miscompares++; $display("FAIL stall_y_valid cycle %0d: got %b, required 1", i, yv); end
            vectors++;
            if (int'(yd) !== held) begin miscompares++; $display("FAIL stall_y_data cycle %0d: got %0d, required %0d", i, yd, held); end
            vectors++;
            if (xr !== 1'b0) begin miscompares++; $display("FAIL stall_x_ready cycle %0d: got %b, required 0", i, xr); end
        end
        for (int i = 0; i < 15; i++) begin
            run_cycle(logic'(i < 12 && $urandom_range(1, 0) == 1), T'($urandom), 1'b1, xr, yv, yd, dn);
            if (yv) begin
                pop_exp(e, ok);
                vectors++;
                if (!ok || int'(yd) !== e) begin miscompares++; $display("FAIL release_out: got %0d, required %0d (pending %b)", yd, e, ok); end
            end
        end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL release_lost: got %0d outputs unsent, required 0", exp_q.size()); end
    endtask

    task automatic test_stream();
        logic xr, yv;
        sample_t yd;
        bit dn, ok;
        bit prev = 1'b0;
        int e;
        for (int i = 0; i < 40; i++) begin
            run_cycle(1'b1, T'($urandom), 1'b1, xr, yv, yd, dn);
            vectors++;
            if (xr !== 1'b1) begin miscompares++; $display("FAIL stream_x_ready cycle %0d: got %b, required 1", i, xr); end
            vectors++;
            if (yv !== logic'(prev)) begin miscompares++; $display("FAIL stream_latency cycle %0d: got y_valid %b, required %b", i, yv, prev); end
            if (yv) begin
                pop_exp(e, ok);
                vectors++;
                if (!ok || int'(yd) !== e) begin miscompares++; $display("FAIL stream_out: got %0d, required %0d (pending %b)", yd, e, ok); end
            end
            prev = dn;
        end
    endtask

    task automatic test_random();
        logic xr, yv, vld, rdy;
        sample_t yd;
        bit dn, ok;
        int e;
        for (int i = 0; i < 400; i++) begin
            vld = logic'($urandom_range(9, 0) < 7);
            rdy = logic'(i >= 395 || $urandom_range(9, 0) < 7);
            if (i >= 395) vld = 1'b0;
            run_cycle(vld, T'($urandom), rdy, xr, yv, yd, dn);
            vectors++;
            if (xr !== (~yv | rdy)) begin miscompares++; $display("FAIL random_x_ready cycle %0d: got %b, required %b", i, xr, ~yv | rdy); end
            if (yv && rdy) begin
                pop_exp(e, ok);
                vectors++;
                if (!ok || int'(yd) !== e) begin miscompares++; $display("FAIL random_out cycle %0d: got %0d, required %0d (pending %b)", i, yd, e, ok); end
            end
        end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL random_lost: got %0d outputs unsent, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reset_mid();
        test_signed();
        test_avg_pairs();
        test_backpressure();
        test_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
